// File: rtl/peak_search_multi_if.sv
// Frame-in / result-out handshake bundle for peak_search_multi.
// slave: the peak search block; master: the xcorr-side driver and result consumer.
interface peak_search_multi_if #(
  parameter int unsigned NUM_XCORRS      = 6,
  parameter int unsigned MAX_LAGS        = 11,
  parameter int unsigned NUM_BITS_XCORRS = 32,
  parameter int unsigned BITS_PER_XCORR  = 6
);
  localparam int unsigned NumLags = 2 * MAX_LAGS + 1;

  logic [NUM_XCORRS*NumLags*NUM_BITS_XCORRS-1:0] data_in;
  logic [NUM_BITS_XCORRS-1:0]                    min_xcorr_val;
  logic                                          data_in_valid;
  logic                                          data_in_ready;
  logic [NUM_XCORRS*BITS_PER_XCORR-1:0]          data_out;
  logic [NUM_XCORRS*NUM_BITS_XCORRS-1:0]         peak_out;
  logic [NUM_XCORRS-1:0]                         peak_found;
  logic                                          data_out_valid;
  logic                                          data_out_ready;

  modport master (
    output data_in, min_xcorr_val, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, peak_out, peak_found, data_out_valid
  );

  modport slave (
    input  data_in, min_xcorr_val, data_in_valid, data_out_ready,
    output data_in_ready, data_out, peak_out, peak_found, data_out_valid
  );
endinterface

// File: rtl/peak_search_multi.sv
// Multi-channel xcorr peak search: captures one frame, scans one lag per cycle across all channels.
// Optional macro PEAK_ABS_EN: rank by saturated magnitude instead of signed value.
module peak_search_multi #(
  parameter int unsigned NUM_XCORRS      = 6,
  parameter int unsigned MAX_LAGS        = 11,
  parameter int unsigned NUM_BITS_XCORRS = 32,
  parameter int unsigned BITS_PER_XCORR  = 6
) (
  input logic              clk,
  input logic              rst_n,
  peak_search_multi_if.slave bus
);
  localparam int unsigned NumLags = 2 * MAX_LAGS + 1;
  localparam int unsigned W       = NUM_BITS_XCORRS;
  localparam int unsigned IW      = BITS_PER_XCORR;
  localparam int unsigned IterW   = $clog2(NumLags);
  localparam logic [IterW-1:0] LastIter = IterW'(NumLags - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                 state_q;
  logic                   in_ready_q;
  logic                   out_valid_q;
  logic [IterW-1:0]       iter_q;
  logic signed [W-1:0]    frame_q [NUM_XCORRS][NumLags];
  logic signed [W-1:0]    thr_q;
  logic signed [W-1:0]    max_q   [NUM_XCORRS];
  logic [IW-1:0]          idx_q   [NUM_XCORRS];
  logic signed [W-1:0]    cand    [NUM_XCORRS];
  logic signed [W-1:0]    max_d   [NUM_XCORRS];
  logic [IW-1:0]          idx_d   [NUM_XCORRS];
  logic [NUM_XCORRS*IW-1:0] data_out_q;
  logic [NUM_XCORRS*W-1:0]  peak_out_q;
  logic [NUM_XCORRS-1:0]    peak_found_q;

  function automatic logic signed [W-1:0] score(input logic signed [W-1:0] v);
`ifdef PEAK_ABS_EN
    // Negating the most-negative code would wrap, so clamp to the largest positive value.
    if (v == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
    return (v < 0) ? -v : v;
`else
    return v;
`endif
  endfunction

  always_comb begin
    for (int unsigned c = 0; c < NUM_XCORRS; c++) begin
      cand[c]  = score(frame_q[c][iter_q]);
      max_d[c] = max_q[c];
      idx_d[c] = idx_q[c];
      // Strict compare keeps the lowest lag on ties.
      if (iter_q == '0 || cand[c] > max_q[c]) begin
        max_d[c] = cand[c];
        idx_d[c] = IW'(iter_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      iter_q       <= '0;
      thr_q        <= '0;
      data_out_q   <= '0;
      peak_out_q   <= '0;
      peak_found_q <= '0;
      for (int unsigned c = 0; c < NUM_XCORRS; c++) begin
        max_q[c] <= '0;
        idx_q[c] <= '0;
        for (int unsigned l = 0; l < NumLags; l++) frame_q[c][l] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.data_in_valid && in_ready_q) begin
            for (int unsigned c = 0; c < NUM_XCORRS; c++) begin
              for (int unsigned l = 0; l < NumLags; l++) begin
                frame_q[c][l] <= bus.data_in[(c*NumLags+l)*W +: W];
              end
            end
            thr_q      <= bus.min_xcorr_val;
            iter_q     <= '0;
            in_ready_q <= 1'b0;
            state_q    <= StScan;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        StScan: begin
          for (int unsigned c = 0; c < NUM_XCORRS; c++) begin
            max_q[c] <= max_d[c];
            idx_q[c] <= idx_d[c];
          end
          iter_q <= iter_q + 1'b1;
          if (iter_q == LastIter) begin
            for (int unsigned c = 0; c < NUM_XCORRS; c++) begin
              data_out_q[c*IW +: IW] <= idx_d[c];
              peak_out_q[c*W +: W]   <= max_d[c];
              peak_found_q[c]        <= (max_d[c] >= thr_q);
            end
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (bus.data_out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_in_ready  = in_ready_q;
  assign bus.data_out_valid = out_valid_q;
  assign bus.data_out       = data_out_q;
  assign bus.peak_out       = peak_out_q;
  assign bus.peak_found     = peak_found_q;
endmodule

// File: tb/tb_peak_search_multi.sv
// Self-checking bench for peak_search_multi; reference model ranks lags with longint arithmetic.
module tb_peak_search_multi;
  localparam int NX   = 6;
  localparam int MAXL = 11;
  localparam int W    = 32;
  localparam int IW   = 6;
  localparam int NL   = 2 * MAXL + 1;
  localparam int DW   = NX * NL * W;
  localparam int OW   = NX * IW;
  localparam int PW   = NX * W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic signed [W-1:0] fr [NX][NL];
  logic [OW-1:0] exp_idx;
  logic [PW-1:0] exp_peak;
  logic [NX-1:0] exp_found;

  peak_search_multi_if #(
    .NUM_XCORRS(NX), .MAX_LAGS(MAXL), .NUM_BITS_XCORRS(W), .BITS_PER_XCORR(IW)
  ) bus_if ();

  peak_search_multi #(
    .NUM_XCORRS(NX), .MAX_LAGS(MAXL), .NUM_BITS_XCORRS(W), .BITS_PER_XCORR(IW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic longint score(input logic signed [W-1:0] v);
    longint x;
    x = longint'(v);
`ifdef PEAK_ABS_EN
    if (x < 0) x = -x;
    if (x > 64'sd2147483647) x = 64'sd2147483647;
`endif
    return x;
  endfunction

  task automatic clear_frame();
    for (int c = 0; c < NX; c++)
      for (int l = 0; l < NL; l++) fr[c][l] = '0;
  endtask

  task automatic rand_frame();
    int mode;
    for (int c = 0; c < NX; c++) begin
      mode = int'($urandom_range(0, 3));
      for (int l = 0; l < NL; l++) begin
        case (mode)
          0: fr[c][l] = $signed($urandom);
          1: fr[c][l] = $signed(32'($urandom_range(0, 20))) - 32'sd10;
          2: fr[c][l] = -$signed(32'($urandom_range(1, 100000)));
          default: fr[c][l] = ($urandom_range(0, 7) == 0) ? 32'sh80000000 : $signed($urandom);
        endcase
      end
    end
  endtask

  task automatic drive_frame();
    logic [DW-1:0] dv;
    logic [W-1:0]  t;
    dv = '0;
    for (int c = NX - 1; c >= 0; c--)
      for (int l = NL - 1; l >= 0; l--) begin
        t  = fr[c][l];
        dv = (dv << W) | DW'(t);
      end
    bus_if.data_in = dv;
  endtask

  task automatic scramble_data_in();
    logic [DW-1:0] dv;
    dv = '0;
    for (int k = 0; k < DW / 32; k++) dv = (dv << 32) | DW'($urandom);
    bus_if.data_in = dv;
  endtask

  task automatic run_model(input logic signed [W-1:0] thr);
    longint best, s;
    int     bi;
    logic [W-1:0]  t;
    logic [IW-1:0] ti;
    exp_idx = '0;
    exp_peak = '0;
    exp_found = '0;
    for (int c = NX - 1; c >= 0; c--) begin
      best = score(fr[c][0]);
      bi   = 0;
      for (int l = 1; l < NL; l++) begin
        s = score(fr[c][l]);
        if (s > best) begin
          best = s;
          bi   = l;
        end
      end
      t  = W'(best);
      ti = IW'(bi);
      exp_idx      = (exp_idx << IW) | OW'(ti);
      exp_peak     = (exp_peak << W) | PW'(t);
      exp_found[c] = (best >= longint'(thr));
    end
  endtask

  task automatic send_frame(input logic signed [W-1:0] thr);
    int k;
    k = 0;
    drive_frame();
    bus_if.min_xcorr_val = thr;
    while (bus_if.data_in_ready !== 1'b1 && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_ready_timeout: got data_in_ready=%b required 1", bus_if.data_in_ready);
    end
    bus_if.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus_if.data_in_valid = 1'b0;
    run_model(thr);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (bus_if.data_out_valid !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic release_out();
    bus_if.data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_if.data_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.data_in        = '0;
    bus_if.min_xcorr_val  = '0;
    bus_if.data_in_valid  = 1'b0;
    bus_if.data_out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (bus_if.data_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b required 0", bus_if.data_in_ready);
    end
    n_tests++;
    if (bus_if.data_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b required 0", bus_if.data_out_valid);
    end
    n_tests++;
    if (bus_if.data_out !== '0 || bus_if.peak_out !== '0 || bus_if.peak_found !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got idx=%h peak=%h found=%h required all 0",
               bus_if.data_out, bus_if.peak_out, bus_if.peak_found);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus_if.data_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b required 1", bus_if.data_in_ready);
    end
  endtask

  task automatic test_basic();
    int cyc;
    logic [OW-1:0] want_idx;
    want_idx = {6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3};
    clear_frame();
    for (int i = 0; i < NX; i++) fr[i][3+i] = 32'sd5000;
    send_frame(32'sd1000);
    n_tests++;
    if (bus_if.data_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_ready: got %b required 0", bus_if.data_in_ready);
    end
    wait_valid(cyc);
    n_tests++;
    if (cyc !== NL) begin
      n_fail++; $display("FAIL basic_latency: got %0d required %0d", cyc, NL);
    end
    n_tests++;
    if (bus_if.data_out !== want_idx) begin
      n_fail++; $display("FAIL basic_idx: got %h required %h", bus_if.data_out, want_idx);
    end
    n_tests++;
    if (bus_if.peak_out !== exp_peak) begin
      n_fail++; $display("FAIL basic_peak: got %h required %h", bus_if.peak_out, exp_peak);
    end
    n_tests++;
    if (bus_if.peak_found !== 6'h3F) begin
      n_fail++; $display("FAIL basic_found: got %h required 3f", bus_if.peak_found);
    end
    release_out();
  endtask

  task automatic test_ties();
    int cyc;
    clear_frame();
    fr[0][4]  = 32'sd7000;
    fr[0][17] = 32'sd7000;
    for (int l = 0; l < NL; l++) fr[1][l] = -32'sd10;
    send_frame(32'sd1000);
    wait_valid(cyc);
    n_tests++;
    if (bus_if.data_out[5:0] !== 6'd4) begin
      n_fail++; $display("FAIL tie_ch0_idx: got %0d required 4", bus_if.data_out[5:0]);
    end
    n_tests++;
    if (bus_if.data_out[11:6] !== 6'd0) begin
      n_fail++; $display("FAIL neg_ch1_idx: got %0d required 0", bus_if.data_out[11:6]);
    end
    n_tests++;
    if (bus_if.peak_found[1] !== 1'b0 || bus_if.peak_found[0] !== 1'b1) begin
      n_fail++; $display("FAIL tie_found: got %b required ch0=1 ch1=0", bus_if.peak_found[1:0]);
    end
    n_tests++;
    if (bus_if.data_out !== exp_idx || bus_if.peak_out !== exp_peak ||
        bus_if.peak_found !== exp_found) begin
      n_fail++;
      $display("FAIL tie_model: got idx=%h peak=%h found=%h required idx=%h peak=%h found=%h",
               bus_if.data_out, bus_if.peak_out, bus_if.peak_found,
               exp_idx, exp_peak, exp_found);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int cyc;
    rand_frame();
    send_frame($signed($urandom));
    wait_valid(cyc);
    for (int k = 0; k < 10; k++) begin
      scramble_data_in();
      @(posedge clk);
      #1;
      n_tests++;
      if (bus_if.data_out_valid !== 1'b1 || bus_if.data_in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_handshake: got valid=%b in_ready=%b required valid=1 in_ready=0",
                 bus_if.data_out_valid, bus_if.data_in_ready);
      end
      n_tests++;
      if (bus_if.data_out !== exp_idx || bus_if.peak_out !== exp_peak ||
          bus_if.peak_found !== exp_found) begin
        n_fail++;
        $display("FAIL stall_hold: got idx=%h found=%h required idx=%h found=%h",
                 bus_if.data_out, bus_if.peak_found, exp_idx, exp_found);
      end
    end
    release_out();
    n_tests++;
    if (bus_if.data_out_valid !== 1'b0 || bus_if.data_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: got valid=%b in_ready=%b required valid=0 in_ready=1",
               bus_if.data_out_valid, bus_if.data_in_ready);
    end
    rand_frame();
    send_frame(32'sd0);
    wait_valid(cyc);
    n_tests++;
    if (cyc !== NL || bus_if.data_out !== exp_idx || bus_if.peak_out !== exp_peak ||
        bus_if.peak_found !== exp_found) begin
      n_fail++;
      $display("FAIL stall_next_frame: got lat=%0d idx=%h found=%h required lat=%0d idx=%h found=%h",
               cyc, bus_if.data_out, bus_if.peak_found, NL, exp_idx, exp_found);
    end
    release_out();
  endtask

  task automatic test_abort();
    int cyc;
    rand_frame();
    send_frame(32'sd0);
    repeat (12) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus_if.data_out_valid !== 1'b0 || bus_if.data_in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_handshake: got valid=%b in_ready=%b required 0 0",
               bus_if.data_out_valid, bus_if.data_in_ready);
    end
    n_tests++;
    if (bus_if.data_out !== '0 || bus_if.peak_out !== '0 || bus_if.peak_found !== '0) begin
      n_fail++;
      $display("FAIL abort_outputs: got idx=%h peak=%h found=%h required all 0",
               bus_if.data_out, bus_if.peak_out, bus_if.peak_found);
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    rand_frame();
    send_frame($signed($urandom));
    wait_valid(cyc);
    n_tests++;
    if (cyc !== NL || bus_if.data_out !== exp_idx || bus_if.peak_out !== exp_peak ||
        bus_if.peak_found !== exp_found) begin
      n_fail++;
      $display("FAIL abort_recover: got lat=%0d idx=%h found=%h required lat=%0d idx=%h found=%h",
               cyc, bus_if.data_out, bus_if.peak_found, NL, exp_idx, exp_found);
    end
    release_out();
  endtask

  task automatic test_abs();
    int cyc;
    logic [IW-1:0] e0i, e1i;
    logic [W-1:0]  e0p, e1p;
`ifdef PEAK_ABS_EN
    e0i = 6'd2;  e0p = 32'd9000; e1i = 6'd5; e1p = 32'h7FFFFFFF;
`else
    e0i = 6'd20; e0p = 32'd8000; e1i = 6'd0; e1p = 32'h0;
`endif
    clear_frame();
    fr[0][2]  = -32'sd9000;
    fr[0][20] = 32'sd8000;
    fr[1][5]  = 32'sh80000000;
    send_frame(32'sd1000);
    wait_valid(cyc);
    n_tests++;
    if (bus_if.data_out[5:0] !== e0i || bus_if.peak_out[31:0] !== e0p) begin
      n_fail++;
      $display("FAIL abs_ch0: got idx=%0d peak=%h required idx=%0d peak=%h",
               bus_if.data_out[5:0], bus_if.peak_out[31:0], e0i, e0p);
    end
    n_tests++;
    if (bus_if.data_out[11:6] !== e1i || bus_if.peak_out[63:32] !== e1p) begin
      n_fail++;
      $display("FAIL abs_most_negative: got idx=%0d peak=%h required idx=%0d peak=%h",
               bus_if.data_out[11:6], bus_if.peak_out[63:32], e1i, e1p);
    end
    n_tests++;
    if (bus_if.data_out !== exp_idx || bus_if.peak_out !== exp_peak ||
        bus_if.peak_found !== exp_found) begin
      n_fail++;
      $display("FAIL abs_model: got idx=%h found=%h required idx=%h found=%h",
               bus_if.data_out, bus_if.peak_found, exp_idx, exp_found);
    end
    release_out();
  endtask

  task automatic test_random();
    int cyc;
    int results;
    logic signed [W-1:0] thr;
    logic got;
    results = 0;
    for (int f = 0; f < 20; f++) begin
      rand_frame();
      thr = ($urandom_range(0, 1) == 0) ? $signed($urandom)
                                        : $signed(32'($urandom_range(0, 200))) - 32'sd100;
      send_frame(thr);
      wait_valid(cyc);
      n_tests++;
      if (cyc !== NL) begin
        n_fail++; $display("FAIL rand_latency[%0d]: got %0d required %0d", f, cyc, NL);
      end
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
        n_tests++;
        if (bus_if.data_out_valid !== 1'b1 || bus_if.data_out !== exp_idx ||
            bus_if.peak_out !== exp_peak || bus_if.peak_found !== exp_found) begin
          n_fail++;
          $display("FAIL rand_result[%0d]: got v=%b idx=%h found=%h required v=1 idx=%h found=%h",
                   f, bus_if.data_out_valid, bus_if.data_out, bus_if.peak_found,
                   exp_idx, exp_found);
        end
        bus_if.data_out_ready = (k >= 8) || ($urandom_range(0, 3) == 0);
        @(posedge clk);
        #1;
        if (bus_if.data_out_ready) begin
          got = 1'b1;
          results++;
        end
        bus_if.data_out_ready = 1'b0;
      end
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #0;
    end
    n_tests++;
    if (results !== 20) begin
      n_fail++; $display("FAIL rand_frame_count: got %0d required 20", results);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_abort();
    test_abs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
